sc_bitstream_decoder: RTL and testbench

Stochastic-to-binary decoder for the sobolflex datapath: it converts unary bitstreams back into binary counts, the reverse of the Sobol-based encoder. Two independent channels share one input port, time-multiplexed by a select line. Each channel counts ones over a fixed window of 2^BITWIDTH accepted bits, then publishes the count with a one-cycle valid pulse.

---
 rtl/sc_bitstream_decoder.sv | 111 +++++++++++
 tb/tb_sc_bitstream_decoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// sc_bitstream_decoder
//
// Stochastic-to-binary decoder. Two independent channels share one bit input,
// time-multiplexed by iSel. Each channel counts ones over a window of
// 2^BITWIDTH accepted bits, then publishes the count on oDataN together with a
// one-cycle oValidN pulse. Back-to-back windows run at full rate.
//
// Optional build macro:
//   SC_DEC_BIPOLAR_EN  - when defined, results are bipolar:
//                        oData = ones - 2^(BITWIDTH-1) in two's complement,
//                        so a stream with p = 0.5 decodes to 0.
//                        When undefined, oData = ones (unipolar, unsigned).
//
// Ports:
//   iClk     in   1           clock, rising edge
//   iRst     in   1           synchronous active-high reset (wins over all)
//   iEn      in   1           iBit is valid and accepted this cycle
//   iSel     in   1           channel of current bit (0 / 1)
//   iBit     in   1           stochastic bitstream sample
//   iClr     in   1           clear in-progress windows on both channels;
//                             drops any bit presented in the same cycle
//   oData0   out  BITWIDTH+1  last completed result of channel 0
//   oData1   out  BITWIDTH+1  last completed result of channel 1
//   oValid0  out  1           one-cycle pulse: oData0 updated
//   oValid1  out  1           one-cycle pulse: oData1 updated
// -----------------------------------------------------------------------------
module sc_bitstream_decoder #(
    parameter int BITWIDTH = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iSel,
    input  logic                iBit,
    input  logic                iClr,
    output logic [BITWIDTH:0]   oData0,
    output logic [BITWIDTH:0]   oData1,
    output logic                oValid0,
    output logic                oValid1
);

    // Window counter value at the final bit of a window.
    localparam logic [BITWIDTH-1:0] WCNT_LAST = {BITWIDTH{1'b1}};

`ifdef SC_DEC_BIPOLAR_EN
    // Bipolar zero point: half the window length.
    localparam logic [BITWIDTH:0] HALF = (BITWIDTH+1)'(1) << (BITWIDTH-1);
`endif

    // Map a ones count (0..2^BITWIDTH) to the published result.
    function automatic logic [BITWIDTH:0] decode(input logic [BITWIDTH:0] ones);
`ifdef SC_DEC_BIPOLAR_EN
        decode = ones - HALF;
`else
        decode = ones;
`endif
    endfunction

    logic [BITWIDTH-1:0] wcnt_r  [2];
    logic [BITWIDTH:0]   acc_r   [2];
    logic [BITWIDTH:0]   data_r  [2];
    logic                valid_r [2];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic              hit_s;
        logic              final_s;
        logic [BITWIDTH:0] sum_s;

        // Channel c owns the incoming bit only when enabled and selected;
        // iClr handling takes precedence inside the register block.
        assign hit_s   = iEn & (iSel == 1'(c));
        assign final_s = hit_s & (wcnt_r[c] == WCNT_LAST);
        // Sum includes the current bit so the final bit lands in the result.
        assign sum_s   = acc_r[c] + (BITWIDTH+1)'(iBit);

        // Per-channel window counter, accumulator, result and pulse registers.
        always_ff @(posedge iClk) begin
            if (iRst) begin
                wcnt_r[c]  <= '0;
                acc_r[c]   <= '0;
                data_r[c]  <= '0;
                valid_r[c] <= 1'b0;
            end else if (iClr) begin
                // Drop partial windows; last published result is kept.
                wcnt_r[c]  <= '0;
                acc_r[c]   <= '0;
                valid_r[c] <= 1'b0;
            end else begin
                valid_r[c] <= final_s;
                if (final_s) begin
                    data_r[c] <= decode(sum_s);
                    acc_r[c]  <= '0;
                    wcnt_r[c] <= '0;
                end else if (hit_s) begin
                    acc_r[c]  <= sum_s;
                    wcnt_r[c] <= wcnt_r[c] + BITWIDTH'(1);
                end else begin
                    acc_r[c]  <= acc_r[c];
                    wcnt_r[c] <= wcnt_r[c];
                end
            end
        end
    end

    assign oData0  = data_r[0];
    assign oData1  = data_r[1];
    assign oValid0 = valid_r[0];
    assign oValid1 = valid_r[1];

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_bitstream_decoder
//
// Self-checking bench for sc_bitstream_decoder (BITWIDTH = 4). A reference
// model counts accepted bits and ones per channel with plain integers and
// publishes a result every 16th accepted bit. Every cycle the DUT outputs are
// compared against the model; each scenario task adds explicit checks of the
// headline values. Honours SC_DEC_BIPOLAR_EN for the expected result mapping.
// -----------------------------------------------------------------------------
module tb_sc_bitstream_decoder;

    localparam int BW  = 4;
    localparam int WIN = 16;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iEn  = 1'b0;
    logic          iSel = 1'b0;
    logic          iBit = 1'b0;
    logic          iClr = 1'b0;
    logic [BW:0]   oData0;
    logic [BW:0]   oData1;
    logic          oValid0;
    logic          oValid1;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_cnt  [2];
    int          m_ones [2];
    logic [BW:0] m_data [2];
    logic        m_valid[2];

    sc_bitstream_decoder #(.BITWIDTH(BW)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iSel   (iSel),
        .iBit   (iBit),
        .iClr   (iClr),
        .oData0 (oData0),
        .oData1 (oData1),
        .oValid0(oValid0),
        .oValid1(oValid1)
    );

    always #5 iClk = ~iClk;

    // Expected published value for a window containing 'ones' ones.
    function automatic logic [BW:0] f(input int ones);
`ifdef SC_DEC_BIPOLAR_EN
        return (BW+1)'(ones - WIN / 2);
`else
        return (BW+1)'(ones);
`endif
    endfunction

    // Drive one cycle, advance the model with the same inputs, sample at +1.
    task automatic step(input logic en, input logic sel, input logic b,
                        input logic clr, input logic rst);
        int c;
        iEn = en; iSel = sel; iBit = b; iClr = clr; iRst = rst;
        @(posedge iClk);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_ones[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0;
            end
        end else if (clr) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_ones[k] = 0; m_valid[k] = 1'b0;
            end
        end else begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            if (en) begin
                c = int'(sel);
                m_cnt[c]  = m_cnt[c] + 1;
                m_ones[c] = m_ones[c] + int'(b);
                if (m_cnt[c] == WIN) begin
                    m_data[c]  = f(m_ones[c]);
                    m_valid[c] = 1'b1;
                    m_cnt[c]   = 0;
                    m_ones[c]  = 0;
                end
            end
        end
        #1;
        iEn = 1'b0; iClr = 1'b0; iRst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if ({oValid1, oValid0, oData1, oData0} !== 12'd0) begin
            bad++;
            $display("FAIL reset_state: got v1=%b v0=%b d1=%0d d0=%0d, want all 0",
                     oValid1, oValid0, oData1, oData0);
        end
    endtask

    task automatic test_all_ones();
        int pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            total++;
            if ({oValid1, oValid0, oData1, oData0} !==
                {m_valid[1], m_valid[0], m_data[1], m_data[0]}) begin
                bad++;
                $display("FAIL all_ones_cycle%0d: got v0=%b d0=%0d v1=%b d1=%0d, want v0=%b d0=%0d v1=%b d1=%0d",
                         i, oValid0, oData0, oValid1, oData1,
                         m_valid[0], m_data[0], m_valid[1], m_data[1]);
            end
            if (oValid0 === 1'b1) pulses++;
        end
        total++;
        if (oValid0 !== 1'b1 || oData0 !== f(16) || pulses != 1 || oValid1 !== 1'b0 || oData1 !== 5'd0) begin
            bad++;
            $display("FAIL all_ones_result: got v0=%b d0=%0d pulses=%0d d1=%0d, want v0=1 d0=%0d pulses=1 d1=0",
                     oValid0, oData0, pulses, oData1, f(16));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (oValid0 !== 1'b0 || oData0 !== f(16)) begin
            bad++;
            $display("FAIL all_ones_pulse_width: got v0=%b d0=%0d, want v0=0 d0=%0d",
                     oValid0, oData0, f(16));
        end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        int sent = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (sent < WIN) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            end else begin
                step(1'b1, 1'b1, (sent % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
                sent++;
            end
            total++;
            if ({oValid1, oValid0, oData1, oData0} !==
                {m_valid[1], m_valid[0], m_data[1], m_data[0]}) begin
                bad++;
                $display("FAIL gaps_cycle: got v1=%b d1=%0d v0=%b, want v1=%b d1=%0d v0=%b",
                         oValid1, oData1, oValid0, m_valid[1], m_data[1], m_valid[0]);
            end
            if (oValid1 === 1'b1) pulses++;
        end
        total++;
        if (oValid1 !== 1'b1 || oData1 !== f(8) || pulses != 1) begin
            bad++;
            $display("FAIL gaps_result: got v1=%b d1=%0d pulses=%0d, want v1=1 d1=%0d pulses=1",
                     oValid1, oData1, pulses, f(8));
        end
    endtask

    task automatic test_interleave();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b1, 1'(i % 2), 1'(i % 2), 1'b0, 1'b0);
            total++;
            if ({oValid1, oValid0, oData1, oData0} !==
                {m_valid[1], m_valid[0], m_data[1], m_data[0]}) begin
                bad++;
                $display("FAIL interleave_cycle%0d: got v0=%b d0=%0d v1=%b d1=%0d, want v0=%b d0=%0d v1=%b d1=%0d",
                         i, oValid0, oData0, oValid1, oData1,
                         m_valid[0], m_data[0], m_valid[1], m_data[1]);
            end
            if (i == 2 * WIN - 2) begin
                total++;
                if (oValid0 !== 1'b1 || oData0 !== f(0) || oValid1 !== 1'b0) begin
                    bad++;
                    $display("FAIL interleave_ch0: got v0=%b d0=%0d v1=%b, want v0=1 d0=%0d v1=0",
                             oValid0, oData0, oValid1, f(0));
                end
            end
        end
        total++;
        if (oValid1 !== 1'b1 || oData1 !== f(16) || oValid0 !== 1'b0) begin
            bad++;
            $display("FAIL interleave_ch1: got v1=%b d1=%0d v0=%b, want v1=1 d1=%0d v0=0",
                     oValid1, oData1, oValid0, f(16));
        end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (oData0 !== f(16) || oValid0 !== 1'b0) begin
            bad++;
            $display("FAIL clear_hold: got v0=%b d0=%0d, want v0=0 d0=%0d",
                     oValid0, oData0, f(16));
        end
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if ({oValid0, oData0} !== {m_valid[0], m_data[0]}) begin
                bad++;
                $display("FAIL clear_cycle%0d: got v0=%b d0=%0d, want v0=%b d0=%0d",
                         i, oValid0, oData0, m_valid[0], m_data[0]);
            end
        end
        total++;
        if (oValid0 !== 1'b1 || oData0 !== f(0)) begin
            bad++;
            $display("FAIL clear_result: got v0=%b d0=%0d, want v0=1 d0=%0d",
                     oValid0, oData0, f(0));
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, (i < 12) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        total++;
        if (oValid0 !== 1'b1 || oData0 !== f(12)) begin
            bad++;
            $display("FAIL reset_pre_window: got v0=%b d0=%0d, want v0=1 d0=%0d",
                     oValid0, oData0, f(12));
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if ({oValid1, oValid0, oData1, oData0} !== 12'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got v1=%b v0=%b d1=%0d d0=%0d, want all 0",
                     oValid1, oValid0, oData1, oData0);
        end
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            total++;
            if ({oValid0, oData0} !== {m_valid[0], m_data[0]}) begin
                bad++;
                $display("FAIL reset_after_cycle%0d: got v0=%b d0=%0d, want v0=%b d0=%0d",
                         i, oValid0, oData0, m_valid[0], m_data[0]);
            end
        end
        total++;
        if (oValid0 !== 1'b1 || oData0 !== f(16)) begin
            bad++;
            $display("FAIL reset_after_result: got v0=%b d0=%0d, want v0=1 d0=%0d",
                     oValid0, oData0, f(16));
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (oValid0 === 1'b1) begin
                pulses++;
                if (first < 0) first = i; else second = i;
                total++;
                if (oData0 !== f(16)) begin
                    bad++;
                    $display("FAIL wrap_data_cycle%0d: got d0=%0d, want %0d", i, oData0, f(16));
                end
            end
        end
        total++;
        if (pulses != 2 || second - first != WIN) begin
            bad++;
            $display("FAIL wrap_spacing: got pulses=%0d spacing=%0d, want pulses=2 spacing=%0d",
                     pulses, second - first, WIN);
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 200) == 0));
            total++;
            if ({oValid1, oValid0, oData1, oData0} !==
                {m_valid[1], m_valid[0], m_data[1], m_data[0]}) begin
                bad++;
                $display("FAIL random_cycle%0d: got v0=%b d0=%0d v1=%b d1=%0d, want v0=%b d0=%0d v1=%b d1=%0d",
                         i, oValid0, oData0, oValid1, oData1,
                         m_valid[0], m_data[0], m_valid[1], m_data[1]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_all_ones();
        test_gaps();
        test_interleave();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
